sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one sram-like master port (toward cache/AXI bridge) between the ifetch
//  (inst) and load/store (data) sram-like ports. Grants one request per cycle and
//  tracks up to OUTSTANDING in-order transactions in an owner FIFO, so each bus
//  data_ok is returned to the port that issued the matching request.
// PARAMETERS
//  OUTSTANDING  2  max accepted-but-unanswered transactions (owner FIFO depth, >=1)
//  STARVE_LIMIT 4  consecutive data grants while inst is waiting before inst is forced
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-low (0 = reset)
//  inst_req/inst_wr/inst_size/inst_addr/inst_wdata/inst_uncached  in  1/1/2/32/32/1  inst request
//  inst_addr_ok   out  1   inst request accepted this cycle
//  inst_data_ok   out  1   inst response valid this cycle
//  inst_rdata     out  32  inst response data
//  data_req/data_wr/data_size/data_addr/data_wdata/data_uncached  in  1/1/2/32/32/1  data request
//  data_addr_ok   out  1   data request accepted this cycle
//  data_data_ok   out  1   data response valid this cycle
//  data_rdata     out  32  data response data
//  bus_req/bus_wr/bus_size/bus_addr/bus_wdata/bus_uncached  out  1/1/2/32/32/1  muxed request
//  bus_addr_ok    in   1   bus accepted request
//  bus_data_ok    in   1   bus response (in request order)
//  bus_rdata      in   32  bus response data
//  err            out  1   sticky: bus_data_ok received with owner FIFO empty
// BEHAVIOUR
//  - Reset (rst=0 at posedge): FIFO empty (count=0, rd/wr ptr=0), starve counter=0,
//    err=0. While rst=0, bus_req, *_addr_ok and *_data_ok are forced to 0.
//  - can_issue = count<OUTSTANDING, OR count==OUTSTANDING && bus_data_ok (pop frees slot).
//  - Grant (combinational): no grant if !can_issue. Otherwise data wins if data_req,
//    unless inst_req && starve==STARVE_LIMIT, then inst wins. inst wins if only inst_req.
//  - bus_req = granted req. bus_wr/size/addr/wdata/uncached = granted port's fields;
//    they equal data fields when nothing is granted.
//  - Granted port's addr_ok = bus_addr_ok; the other port's addr_ok = 0.
//  - Push: at bus_req&bus_addr_ok, write owner bit (1=data) at wr ptr. Pop at
//    bus_data_ok when count>0. inst_data_ok = bus_data_ok & head==0;
//    data_data_ok = bus_data_ok & head==1. Both rdata outputs = bus_rdata.
//  - Push and pop in one cycle: count unchanged, both pointers advance. Pointers wrap
//    modulo OUTSTANDING. Response is zero-latency (same cycle as bus_data_ok).
//  - Starve counter: at an accepted data push while inst_req=1, increment, saturating
//    at STARVE_LIMIT. Clear at an accepted inst push or whenever inst_req=0.
//  - bus_data_ok with count==0: drop it (no port data_ok), set err=1. err clears only on reset.
//  - Requesters may change or drop req before addr_ok. The arbiter holds no request
//    state, so the grant is re-evaluated every cycle.
//  - Reset mid-transaction: owner FIFO is discarded. The bus side must be reset with
//    this block; otherwise stray responses set err.
// TESTING
//  1 inst_req only, bus_addr_ok=1, data_ok after 1 cycle, rdata=32'h2402_0001 ->
//    inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=32'h2402_0001 in cycle 1;
//    data_data_ok stays 0.
//  2 inst_req and data_req both held for 1 cycle -> data granted (bus_addr=data_addr,
//    data_addr_ok=1, inst_addr_ok=0); inst is granted in the next cycle.
//  3 OUTSTANDING=2; accept data then inst with no bus_data_ok -> 3rd request stalls
//    (bus_req=0). Then bus_data_ok twice -> data_data_ok, then inst_data_ok, in order.
//  4 FIFO full; bus_data_ok and a new inst_req in the same cycle -> pop and push
//    together, count stays 2, inst_addr_ok=1.
//  5 data_req held high, inst_req high, STARVE_LIMIT=4 -> 4 data grants, then
//    1 inst grant, then data grants resume.
//  6 bus_data_ok pulse with FIFO empty -> no port data_ok, err=1 until rst=0.
//    rst=0 mid-run with 2 outstanding -> count=0, bus_req=0.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// sram-like port bundle shared by the inst, data and bus sides.
// master drives the request; slave answers with addr_ok/data_ok/rdata.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncached;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata, uncached,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata, uncached,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-into-one sram-like arbiter (inst + data onto one bus port).
// An in-order owner FIFO routes each bus response back to its issuer.
module sram_like_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_like_arbiter_if.slave   inst,
    sram_like_arbiter_if.slave   data,
    sram_like_arbiter_if.master  bus,
    output logic                 err
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
    localparam logic [SW-1:0] STV_MAX  = SW'(STARVE_LIMIT);

    logic [OUTSTANDING-1:0] owner;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve;

    logic full;
    logic empty;
    logic can_issue;
    logic force_inst;
    logic pick_inst;
    logic gnt_inst;
    logic gnt_data;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CNT_MAX);
    assign empty      = (count == '0);
    assign pop        = bus.data_ok & ~empty;

    // A full FIFO can still take a request if a response frees a slot now.
    assign can_issue  = ~full | bus.data_ok;

    assign force_inst = inst.req & (starve == STV_MAX);
    assign pick_inst  = inst.req & (~data.req | force_inst);

    assign gnt_inst   = rst & can_issue & pick_inst;
    assign gnt_data   = rst & can_issue & data.req & ~pick_inst;
    assign push       = (gnt_inst | gnt_data) & bus.addr_ok;
    assign head       = owner[rd_ptr];

    // Request mux: data fields are the idle default.
    always_comb begin
        bus.req      = gnt_inst | gnt_data;
        bus.wr       = data.wr;
        bus.size     = data.size;
        bus.addr     = data.addr;
        bus.wdata    = data.wdata;
        bus.uncached = data.uncached;
        if (gnt_inst) begin
            bus.wr       = inst.wr;
            bus.size     = inst.size;
            bus.addr     = inst.addr;
            bus.wdata    = inst.wdata;
            bus.uncached = inst.uncached;
        end
    end

    // Handshake fan-out to the two requesters.
    always_comb begin
        inst.addr_ok = gnt_inst & bus.addr_ok;
        data.addr_ok = gnt_data & bus.addr_ok;
        inst.data_ok = rst & pop & ~head;
        data.data_ok = rst & pop & head;
        inst.rdata   = bus.rdata;
        data.rdata   = bus.rdata;
    end

    // Owner storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            owner[wr_ptr] <= gnt_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Counts data wins while inst waits; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve <= '0;
        end else if (!inst.req) begin
            starve <= '0;
        end else if (push && gnt_inst) begin
            starve <= '0;
        end else if (push && gnt_data && starve != STV_MAX) begin
            starve <= starve + 1'b1;
        end
    end

    // Sticky flag for a response that has no owner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (bus.data_ok && empty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed cases then random traffic,
// all checked against a queue-based owner/starvation model.
module tb_sram_like_arbiter;

    localparam int OUTST = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    always #5 clk = ~clk;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if bus_if ();

    sram_like_arbiter #(
        .OUTSTANDING  (OUTST),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .inst (inst_if),
        .data (data_if),
        .bus  (bus_if),
        .err  (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    bit owner_q[$];
    int starve_m = 0;
    bit err_m    = 1'b0;
    int win      = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = no grant, 1 = inst, 2 = data
    function automatic int pick();
        int n;
        n = owner_q.size();
        if (!rst) return 0;
        if (!(n < OUTST || (n == OUTST && bus_if.data_ok))) return 0;
        if (data_if.req && inst_if.req && starve_m == LIMIT) return 1;
        if (data_if.req) return 2;
        if (inst_if.req) return 1;
        return 0;
    endfunction

    task automatic drive(input bit r, input bit ir, input bit dr,
                         input bit baok, input bit bdok,
                         input logic [31:0] rd);
        @(negedge clk);
        rst               = r;
        inst_if.req       = ir;
        inst_if.wr        = 1'($urandom);
        inst_if.size      = 2'($urandom);
        inst_if.addr      = $urandom;
        inst_if.wdata     = $urandom;
        inst_if.uncached  = 1'($urandom);
        data_if.req       = dr;
        data_if.wr        = 1'($urandom);
        data_if.size      = 2'($urandom);
        data_if.addr      = $urandom;
        data_if.wdata     = $urandom;
        data_if.uncached  = 1'($urandom);
        bus_if.addr_ok    = baok;
        bus_if.data_ok    = bdok;
        bus_if.rdata      = rd;
        #1;
        win = pick();
    endtask

    task automatic check_model();
        bit resp;
        bit hd;
        resp = rst && bus_if.data_ok && owner_q.size() > 0;
        hd   = (owner_q.size() > 0) ? owner_q[0] : 1'b0;
        chk("bus_req", bus_if.req, win != 0);
        if (win == 1) begin
            chk("bus_addr", bus_if.addr, inst_if.addr);
            chk("bus_wdata", bus_if.wdata, inst_if.wdata);
            chk("bus_attr", {bus_if.wr, bus_if.size, bus_if.uncached},
                {inst_if.wr, inst_if.size, inst_if.uncached});
        end else begin
            chk("bus_addr", bus_if.addr, data_if.addr);
            chk("bus_wdata", bus_if.wdata, data_if.wdata);
            chk("bus_attr", {bus_if.wr, bus_if.size, bus_if.uncached},
                {data_if.wr, data_if.size, data_if.uncached});
        end
        chk("inst_addr_ok", inst_if.addr_ok, win == 1 && bus_if.addr_ok);
        chk("data_addr_ok", data_if.addr_ok, win == 2 && bus_if.addr_ok);
        chk("inst_data_ok", inst_if.data_ok, resp && !hd);
        chk("data_data_ok", data_if.data_ok, resp && hd);
        chk("inst_rdata", inst_if.rdata, bus_if.rdata);
        chk("data_rdata", data_if.rdata, bus_if.rdata);
        if (rst) chk("err", err, err_m);
    endtask

    task automatic tick();
        bit push;
        @(posedge clk);
        push = (win != 0) && bus_if.addr_ok;
        if (!rst) begin
            owner_q.delete();
            starve_m = 0;
            err_m    = 1'b0;
        end else begin
            if (bus_if.data_ok) begin
                if (owner_q.size() == 0) err_m = 1'b1;
                else void'(owner_q.pop_front());
            end
            if (push) owner_q.push_back(win == 2);
            if (!inst_if.req) starve_m = 0;
            else if (push && win == 1) starve_m = 0;
            else if (push && win == 2 && starve_m < LIMIT) starve_m++;
        end
    endtask

    task automatic cyc(input bit r, input bit ir, input bit dr,
                       input bit baok, input bit bdok,
                       input logic [31:0] rd);
        drive(r, ir, dr, baok, bdok, rd);
        check_model();
        tick();
    endtask

    initial begin
        int exp_inst [6];
        exp_inst = '{0, 0, 0, 0, 1, 0};

        // reset holds everything quiet
        drive(0, 1, 1, 1, 1, 32'h0);
        check_model();
        chk("rst_bus_req", bus_if.req, 0);
        tick();
        cyc(0, 1, 1, 1, 0, 32'h0);

        // inst alone, one-cycle response
        drive(1, 1, 0, 1, 0, 32'h0);
        check_model();
        chk("t1_iaok", inst_if.addr_ok, 1);
        tick();
        drive(1, 0, 0, 0, 1, 32'h2402_0001);
        check_model();
        chk("t1_idok", inst_if.data_ok, 1);
        chk("t1_rdata", inst_if.rdata, 32'h2402_0001);
        chk("t1_ddok", data_if.data_ok, 0);
        tick();

        // both request: data first, inst next cycle
        drive(1, 1, 1, 1, 0, 32'h0);
        check_model();
        chk("t2_daok", data_if.addr_ok, 1);
        chk("t2_iaok", inst_if.addr_ok, 0);
        chk("t2_addr", bus_if.addr, data_if.addr);
        tick();
        drive(1, 1, 0, 1, 0, 32'h0);
        check_model();
        chk("t2_inext", inst_if.addr_ok, 1);
        tick();
        cyc(1, 0, 0, 0, 1, $urandom);
        cyc(1, 0, 0, 0, 1, $urandom);

        // FIFO full stalls, then in-order responses
        cyc(1, 0, 1, 1, 0, 32'h0);
        cyc(1, 1, 0, 1, 0, 32'h0);
        drive(1, 1, 1, 1, 0, 32'h0);
        check_model();
        chk("t3_stall", bus_if.req, 0);
        tick();
        // full + response + new inst: pop and push together
        drive(1, 1, 0, 1, 1, 32'h1111_2222);
        check_model();
        chk("t4_iaok", inst_if.addr_ok, 1);
        chk("t3_ddok", data_if.data_ok, 1);
        tick();
        drive(1, 1, 1, 1, 0, 32'h0);
        check_model();
        chk("t4_still_full", bus_if.req, 0);
        tick();
        drive(1, 0, 0, 0, 1, 32'h3333_4444);
        check_model();
        chk("t3_idok", inst_if.data_ok, 1);
        tick();
        cyc(1, 0, 0, 0, 1, $urandom);

        // starvation: DDDD I D
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 1, 1, k != 0, $urandom);
            check_model();
            chk("t5_inst_gnt", inst_if.addr_ok, exp_inst[k]);
            tick();
        end
        cyc(1, 0, 0, 0, 1, $urandom);

        // random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 49) != 0,
                1'($urandom), 1'($urandom), 1'($urandom),
                (owner_q.size() > 0) ? 1'($urandom) : 1'b0,
                $urandom);
        end

        // stray response sets sticky err
        cyc(0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 1, 32'hdead_beef);
        check_model();
        chk("t6_stray_idok", inst_if.data_ok, 0);
        chk("t6_stray_ddok", data_if.data_ok, 0);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check_model();
        chk("t6_err", err, 1);
        tick();

        // reset with two outstanding
        cyc(1, 1, 1, 1, 0, 32'h0);
        cyc(1, 1, 0, 1, 0, 32'h0);
        drive(0, 1, 1, 1, 1, 32'h0);
        check_model();
        chk("t6_rst_req", bus_if.req, 0);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check_model();
        chk("t6_err_clr", err, 0);
        tick();
        cyc(1, 1, 1, 1, 0, 32'h0);
        cyc(1, 1, 1, 1, 0, 32'h0);
        drive(1, 1, 1, 1, 0, 32'h0);
        check_model();
        chk("t6_empty_after_rst", bus_if.req, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
